// File: rtl/gray_decoder.sv
// Gray-code stream decoder and link monitor: converts accepted codes to binary,
// counts max->0 wraps and flags any non +1 step. Define GRAY_STICKY_ERR_EN for a sticky Err.
module gray_decoder #(
   parameter int WIDTH  = 3,
   parameter int WRAP_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              In_valid,
   input  logic [WIDTH-1:0]  Gray_in,
   output logic [WIDTH-1:0]  Bin_out,
   output logic              Out_valid,
   output logic              Wrap,
   output logic [WRAP_W-1:0] Wrap_count,
   output logic              Err,
   output logic              Locked
);

   typedef enum logic {EMPTY = 1'b0, LOCK = 1'b1} state_t;

   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_bin, w_bin_nxt;
   logic               r_out_valid, w_out_valid_nxt;
   logic               r_wrap, w_wrap_nxt;
   logic [WRAP_W-1:0]  r_wrap_count, w_wrap_count_nxt;
   logic               r_err, w_err_nxt;

   logic [WIDTH-1:0]   w_bin;
   logic [WIDTH-1:0]   w_bin_inc;

   // Each binary bit is the parity of the gray bits at and above it.
   for (genvar i = 0; i < WIDTH; i++) begin : g_conv
      assign w_bin[i] = ^Gray_in[WIDTH-1:i];
   end

   assign w_bin_inc = r_bin + 1'b1;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= EMPTY;
         r_bin        <= '0;
         r_out_valid  <= 1'b0;
         r_wrap       <= 1'b0;
         r_wrap_count <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bin        <= w_bin_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_wrap       <= w_wrap_nxt;
         r_wrap_count <= w_wrap_count_nxt;
         r_err        <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_bin_nxt        = r_bin;
      w_out_valid_nxt  = r_out_valid;
      w_wrap_nxt       = 1'b0;
      w_wrap_count_nxt = r_wrap_count;
`ifdef GRAY_STICKY_ERR_EN
      w_err_nxt        = r_err;
`else
      w_err_nxt        = 1'b0;
`endif
      if (In_valid) begin
         case (r_state)
            EMPTY: begin
               w_bin_nxt       = w_bin;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = LOCK;
            end
            LOCK: begin
               if (w_bin == r_bin) begin
                  w_bin_nxt = r_bin;
               end else if (w_bin == w_bin_inc) begin
                  w_bin_nxt = w_bin;
                  if (&r_bin) begin
                     w_wrap_nxt = 1'b1;
                     if (!(&r_wrap_count))
                        w_wrap_count_nxt = r_wrap_count + 1'b1;
                  end
               end else begin
                  // Any other step: flag it and resynchronise to the new code.
                  w_err_nxt = 1'b1;
                  w_bin_nxt = w_bin;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   assign Bin_out    = r_bin;
   assign Out_valid  = r_out_valid;
   assign Wrap       = r_wrap;
   assign Wrap_count = r_wrap_count;
   assign Err        = r_err;
   assign Locked     = (r_state == LOCK);

endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
Receive-side counterpart of the gray counter. Samples a gray-coded count stream (the counter's Output/En pair), converts each code to binary, and tracks wrap-arounds. Checks that successive codes advance by exactly one step forward and flags any skipped, backward or multi-bit transition. Sits downstream of the gray counter, in the same clock domain, as a decoder and link monitor.

Parameters:
WIDTH, 3, bit width of gray code and binary output (>=2)
WRAP_W, 8, width of the saturating wrap counter

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
In_valid  input  1  Gray_in qualifier; sampled only when high
Gray_in  input  WIDTH  gray code from the counter
Bin_out  output  WIDTH  registered binary equivalent of last accepted code
Out_valid  output  1  high once a first code has been accepted
Wrap  output  1  one-cycle pulse on a max->0 step
Wrap_count  output  WRAP_W  saturating count of Wrap pulses
Err  output  1  transition error flag (one-cycle pulse by default)
Locked  output  1  high in state LOCK

Behaviour:
- One clock; Reset is synchronous and active-high; every output updates only on the rising edge of Clk.
- Reset values: Bin_out=0, Out_valid=0, Wrap=0, Wrap_count=0, Err=0, Locked=0; state=EMPTY; internal prev_bin=0.
- Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Combinational, then registered. Latency is 1 cycle from an In_valid sample to Bin_out.
- States:
  - EMPTY: no reference code yet. On In_valid: accept the code with no check, Bin_out=prev_bin=bin(Gray_in), Out_valid=1, go to LOCK.
  - LOCK: each In_valid sample is classified against prev_bin, where n=bin(Gray_in):
    - n==prev_bin: hold. No update, no Err, no Wrap.
    - n==prev_bin+1 mod 2^WIDTH: accept and update Bin_out/prev_bin. If prev_bin==2^WIDTH-1 and n==0, pulse Wrap and increment Wrap_count, saturating at 2^WRAP_W-1.
    - Any other n (backward, skip, multi-bit change): pulse Err, resynchronise (Bin_out=prev_bin=n), stay in LOCK. No Wrap, even if n==0.
- In_valid low: all state holds; Wrap and Err are 0 that cycle.
- Wrap and Err are never both high in one cycle.
- Reset asserted mid-stream takes priority over In_valid. The next valid sample after Reset is accepted from EMPTY without error.
- Locked=1 exactly when state==LOCK.
- Arithmetic: the +1 comparison is mod 2^WIDTH. Wrap_count never rolls over.

Optional Feature:
GRAY_STICKY_ERR_EN
- Defined: Err is sticky. Once set, it stays high until Reset. Decoding, resync and Wrap continue normally.
- Undefined: Err is a one-cycle pulse per offending sample (default).

Test Plan:
1. Reset, then In_valid=1 with 3-bit gray codes 000,001,011,010,110,111,101,100 -> Bin_out 0..7 one cycle later, Out_valid=1 from the first accept, Err=0, Wrap=0.
2. Continue from 100 with 000 -> Wrap=1 for exactly one cycle, Wrap_count=1, Bin_out=0. Then 001 -> Wrap=0, Bin_out=1.
3. At Bin_out=1 (gray 001), feed 010 (bin 3, skip) -> Err pulse, Bin_out=3. Then 110 (bin 4) -> accepted, Err=0. Feed 010 (bin 3, backward) -> Err pulse, Bin_out=3.
4. Hold code 011 with In_valid=1 for 3 cycles, then In_valid=0 for 2 cycles while Gray_in changes to 111 -> Bin_out stays 2, no Err, no Wrap.
5. WRAP_W=2: cycle a full sequence 5 times -> Wrap_count goes 1,2,3,3,3.
6. Assert Reset mid-sequence at Bin_out=5 -> next cycle all outputs 0 and Locked=0. Next valid code 111 -> Bin_out=5, Out_valid=1, no Err. With GRAY_STICKY_ERR_EN defined, repeat case 3 -> Err stays 1 until Reset.
